// File: rtl/uart_tx_fifo_if.sv
// System/transmitter-side bundle for the UART TX FIFO; master is the environment
// (byte source plus transmitter done pulse), slave is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_din;
  logic              tx_done_tick;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, level, overflow, busy, tx_start, tx_din
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, level, overflow, busy, tx_start, tx_din
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter: push to tx_start is 2 cycles when idle;
// a push into a full FIFO is dropped and flagged, and each frame waits for tx_done_tick.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp, rp;
  logic [ADDR_W:0]   level_q;
  logic [DATA_W-1:0] tx_din_q;
  logic              overflow_q;
  logic              full, empty, push, pop;
  logic              tx_start_c, busy_c;

  // Flags come from the registered level only, so a same-cycle pop never frees a slot.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = bus.wr_en && !full;
  assign pop   = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      level_q    <= '0;
      tx_din_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp       <= rp + 1'b1;
        tx_din_q <= mem[rp];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!empty) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (bus.tx_done_tick) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_c = (state == S_LAUNCH);
    busy_c     = (state != S_IDLE);
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_c;
  assign bus.tx_start = tx_start_c;
  assign bus.tx_din   = tx_din_q;
endmodule
